// File: rtl/core_pkg.sv
// Shared decode definitions: RV32 opcodes, the canonical NOP, immediate formats.
package core_pkg;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE
  } imm_fmt_e;

  // Map an opcode to the layout of its immediate field.
  function automatic imm_fmt_e imm_fmt(input logic [6:0] op);
    imm_fmt_e f;
    case (op)
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: f = IMM_I;
      OP_STORE:                            f = IMM_S;
      OP_BRANCH:                           f = IMM_B;
      OP_LUI, OP_AUIPC:                    f = IMM_U;
      OP_JAL:                              f = IMM_J;
      default:                             f = IMM_NONE;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate extraction for RV32 instructions; sign comes from instr[31].
module imm_gen
  import core_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm
);

  // Reassemble the immediate according to the opcode's format.
  always_comb begin
    imm = '0;
    case (imm_fmt(instr[6:0]))
      IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U: imm = {instr[31:12], 12'b0};
      IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/instdec_queue.sv
// Fetch-to-decode instruction queue with field/immediate decode of the head.
module instdec_queue
  import core_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [XLEN-1:0]                pc_in,
  input  logic [XLEN-1:0]                instr_in,
  input  logic                           flush,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [XLEN-1:0]                pc_out,
  output logic [XLEN-1:0]                instr_out,
  output logic [4:0]                     rs1,
  output logic [4:0]                     rs2,
  output logic [4:0]                     rd,
  output logic [6:0]                     opcode,
  output logic [31:0]                    imm,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   cnt;
  logic            push, pop;

  // in_ready looks only at occupancy, so a full queue refuses a push even
  // when the head is being consumed in the same cycle.
  assign in_ready  = (cnt != FULL);
  assign out_valid = (cnt != '0);
  assign push      = in_valid && in_ready && !flush && !rst;
  assign pop       = out_valid && out_ready && !flush && !rst;
  assign count     = cnt;

  // Pointer/occupancy update; reset beats flush, flush beats push/pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage; contents are don't-care until pushed, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= pc_in;
      instr_mem[wr_ptr] <= instr_in;
    end
  end

  // Empty queue presents a NOP at pc 0 so decode sees harmless fields.
  assign instr_out = out_valid ? instr_mem[rd_ptr] : NOP;
  assign pc_out    = out_valid ? pc_mem[rd_ptr]    : '0;

  assign rs1    = instr_out[19:15];
  assign rs2    = instr_out[24:20];
  assign rd     = instr_out[11:7];
  assign opcode = instr_out[6:0];

  // NOP decodes to a zero immediate, so no extra gating on out_valid.
  imm_gen u_imm_gen (
    .instr (instr_out[31:0]),
    .imm   (imm)
  );

endmodule

// File: tb/tb_instdec_queue.sv
// Randomized + directed bench for instdec_queue against a queue-based model.
module tb_instdec_queue;

  localparam int DEPTH = 4;

  logic        clk, rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] pc_in, instr_in, pc_out, instr_out, imm;
  logic [4:0]  rs1, rs2, rd;
  logic [6:0]  opcode;
  logic [2:0]  count;

  int tests = 0;
  int fails = 0;

  logic [63:0] mq[$];   // {pc, instr}, head at index 0

  instdec_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pc_in(pc_in), .instr_in(instr_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .pc_out(pc_out), .instr_out(instr_out),
    .rs1(rs1), .rs2(rs2), .rd(rd), .opcode(opcode), .imm(imm), .count(count)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_imm(input logic [31:0] i);
    logic [6:0] op;
    op = i[6:0];
    case (op)
      7'h13, 7'h03, 7'h67, 7'h73: return {{20{i[31]}}, i[31:20]};
      7'h23: return {{20{i[31]}}, i[31:25], i[11:7]};
      7'h63: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      7'h37, 7'h17: return {i[31:12], 12'b0};
      7'h6F: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  task automatic compare();
    logic [31:0] ei, ep;
    int n;
    n  = mq.size();
    ei = (n != 0) ? mq[0][31:0]  : 32'h13;
    ep = (n != 0) ? mq[0][63:32] : 32'h0;
    chk("count",     32'(count),     32'(n));
    chk("out_valid", 32'(out_valid), 32'(n != 0));
    chk("in_ready",  32'(in_ready),  32'(n != DEPTH));
    chk("instr_out", instr_out, ei);
    chk("pc_out",    pc_out,    ep);
    chk("rs1",       32'(rs1),    32'(ei[19:15]));
    chk("rs2",       32'(rs2),    32'(ei[24:20]));
    chk("rd",        32'(rd),     32'(ei[11:7]));
    chk("opcode",    32'(opcode), 32'(ei[6:0]));
    chk("imm",       imm,       ref_imm(ei));
  endtask

  task automatic model_update();
    bit do_pop, do_push;
    if (rst || flush) begin
      mq.delete();
    end else begin
      do_pop  = (mq.size() != 0) && out_ready;
      do_push = in_valid && (mq.size() != DEPTH);
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back({pc_in, instr_in});
    end
  endtask

  // One cycle: inputs already driven; check mid-cycle, then advance model.
  task automatic step();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic rdy, input logic fl);
    in_valid = v; pc_in = pc; instr_in = ins; out_ready = rdy; flush = fl;
  endtask

  logic [6:0] ops [10];

  initial begin
    ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
    rst = 1; drive(0, 0, 0, 0, 0);
    @(posedge clk); #1;
    step();
    // reset state
    chk("rst_count", 32'(count), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_instr_nop", instr_out, 32'h13);
    rst = 0;

    // addi x1,x0,10 at pc 0x100
    drive(1, 32'h100, 32'h00A00093, 0, 0); step();
    drive(0, 0, 0, 0, 0);
    chk("addi_out_valid", 32'(out_valid), 1);
    chk("addi_rd", 32'(rd), 1);
    chk("addi_rs1", 32'(rs1), 0);
    chk("addi_imm", imm, 32'h0000000A);
    chk("addi_count", 32'(count), 1);
    chk("addi_pc", pc_out, 32'h100);
    drive(0, 0, 0, 1, 0); step();

    // fill with out_ready=0 for 5 cycles
    for (int k = 0; k < 5; k++) begin
      drive(1, 32'h200 + 32'(4*k), $urandom(), 0, 0); step();
      if (k == 3) begin
        chk("full_in_ready", 32'(in_ready), 0);
        chk("full_count4", 32'(count), 4);
      end
    end
    chk("full_count_after5", 32'(count), 4);
    chk("full_head_pc", pc_out, 32'h200);

    // full + pop: no push this cycle
    drive(1, 32'h300, $urandom(), 1, 0); step();
    chk("fullpop_count", 32'(count), 3);
    chk("fullpop_in_ready", 32'(in_ready), 1);
    chk("fullpop_head_pc", pc_out, 32'h204);

    // flush with push pending
    drive(1, 32'h400, $urandom(), 0, 1); step();
    chk("flush_count", 32'(count), 0);
    chk("flush_out_valid", 32'(out_valid), 0);
    chk("flush_instr_nop", instr_out, 32'h13);

    // branch and jal immediates
    drive(1, 32'h40, 32'hFE000EE3, 0, 0); step();
    chk("beq_imm", imm, 32'hFFFFFFFC);
    drive(1, 32'h44, 32'h800000EF, 1, 0); step();
    chk("jal_imm", imm, 32'hFFF00000);
    chk("jal_count", 32'(count), 1);

    // streaming through the pointer wrap
    drive(0, 0, 0, 0, 1); step();
    drive(1, 32'h600, $urandom(), 0, 0); step();
    for (int k = 0; k < 10; k++) begin
      drive(1, 32'h604 + 32'(4*k), $urandom(), 1, 0); step();
      chk("stream_count", 32'(count), 1);
      chk("stream_pc", pc_out, 32'h604 + 32'(4*k));
    end

    // reset mid-stream, then first push
    drive(1, 32'h700, $urandom(), 0, 0); step(); step();
    rst = 1; drive(1, 32'h708, $urandom(), 1, 0); step();
    rst = 0;
    chk("midrst_count", 32'(count), 0);
    drive(1, 32'h500, 32'h00100113, 0, 0); step();
    drive(0, 0, 0, 0, 0);
    chk("midrst_push_valid", 32'(out_valid), 1);
    chk("midrst_push_pc", pc_out, 32'h500);

    // randomized traffic
    for (int k = 0; k < 500; k++) begin
      logic [31:0] ins;
      ins = $urandom();
      if ($urandom_range(0, 3) != 0) ins[6:0] = ops[$urandom_range(0, 9)];
      rst = ($urandom_range(0, 63) == 0);
      drive($urandom_range(0, 9) < 7, $urandom(), ins,
            $urandom_range(0, 9) < 6, $urandom_range(0, 15) == 0);
      step();
    end
    rst = 0; drive(0, 0, 0, 0, 0); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
